seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for a 6-digit common-anode/cathode 7-segment display.

---
 rtl/seg7_pkg.sv | 56 +++++
 rtl/seg7_scan_driver_decode.sv | 17 +
 rtl/seg7_scan_driver.sv | 182 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment scan driver.
//   - seg7_code_t : 5-bit character code (bit 4 selects the symbol page)
//   - seg7_pat_t  : 7-bit segment pattern {g,f,e,d,c,b,a}, active-high (1 = lit)
//   - SYM_*       : symbol-page character codes
//   - seg7_decode : code -> active-high segment pattern
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [4:0] seg7_code_t;
    typedef logic [6:0] seg7_pat_t;

    localparam int NUM_DIGITS = 6;

    localparam seg7_code_t SYM_BLANK = 5'h10;
    localparam seg7_code_t SYM_DASH  = 5'h11;
    localparam seg7_code_t SYM_P     = 5'h12;
    localparam seg7_code_t SYM_L     = 5'h13;

    // Codes 00..0F show a hex digit; codes 10..1F are the symbol page,
    // where anything not explicitly defined renders as blank.
    function automatic seg7_pat_t seg7_decode(input seg7_code_t code);
        seg7_pat_t pat;
        pat = 7'h00;
        if (!code[4]) begin
            case (code[3:0])
                4'h0:    pat = 7'h3F;
                4'h1:    pat = 7'h06;
                4'h2:    pat = 7'h5B;
                4'h3:    pat = 7'h4F;
                4'h4:    pat = 7'h66;
                4'h5:    pat = 7'h6D;
                4'h6:    pat = 7'h7D;
                4'h7:    pat = 7'h07;
                4'h8:    pat = 7'h7F;
                4'h9:    pat = 7'h6F;
                4'hA:    pat = 7'h77;
                4'hB:    pat = 7'h7C;
                4'hC:    pat = 7'h39;
                4'hD:    pat = 7'h5E;
                4'hE:    pat = 7'h79;
                default: pat = 7'h71;
            endcase
        end else begin
            case (code)
                SYM_DASH: pat = 7'h40;
                SYM_P:    pat = 7'h73;
                SYM_L:    pat = 7'h38;
                default:  pat = 7'h00;
            endcase
        end
        return pat;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational character decoder, a thin wrapper around the package function
// so the decode shows up as its own instance in the hierarchy.
//   code_i [4:0] : character code
//   seg_o  [6:0] : segment pattern {g,f,e,d,c,b,a}, active-high
// -----------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [4:0] code_i,
    output logic [6:0] seg_o
);

    assign seg_o = seg7_pkg::seg7_decode(code_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for a 6-digit 7-segment display. One digit is
// scanned per slot of SLOT_CYC clocks; the first BLANK_CYC clocks of every
// slot keep all anodes off to suppress ghosting. Character codes are latched
// into a shadow bank once per frame so a frame never mixes old and new codes.
//
// Ports
//   clk           : system clock
//   rst_n         : asynchronous reset, active-low
//   en_i          : display enable
//   in0_i..in5_i  : character codes, in0_i = rightmost digit (an_o[0])
//   dp_in_i [5:0] : decimal-point request per digit, same mapping as an_o
//   an_o    [5:0] : anode selects (registered, polarity per AN_ACTIVE_LOW)
//   seg_o   [6:0] : segments {g,f,e,d,c,b,a} (registered, per SEG_ACTIVE_LOW)
//   dp_o          : decimal point (registered, per SEG_ACTIVE_LOW)
//   frame_tick_o  : one-cycle pulse for each frame-boundary shadow capture
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SLOT_CYC       = 50_000,
    parameter int BLANK_CYC      = 500,
    parameter int CNT_W          = 16,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [4:0] in0_i,
    input  logic [4:0] in1_i,
    input  logic [4:0] in2_i,
    input  logic [4:0] in3_i,
    input  logic [4:0] in4_i,
    input  logic [4:0] in5_i,
    input  logic [5:0] dp_in_i,
    output logic [5:0] an_o,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic       frame_tick_o
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    generate
        if (SLOT_CYC < 2) begin : g_bad_slot
            $error("seg7_scan_driver: SLOT_CYC must be >= 2");
        end
        if (BLANK_CYC < 0 || BLANK_CYC >= SLOT_CYC) begin : g_bad_blank
            $error("seg7_scan_driver: BLANK_CYC must be in 0..SLOT_CYC-1");
        end
        if (CNT_W < 1 || (CNT_W < 31 && (1 << CNT_W) <= SLOT_CYC - 1)) begin : g_bad_cntw
            $error("seg7_scan_driver: CNT_W too small for SLOT_CYC");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
    localparam logic [2:0]       IDX_LAST  = 3'(NUM_DIGITS - 1);

    // Idle (deasserted) levels of the physical outputs
    localparam logic [5:0] AN_IDLE  = AN_ACTIVE_LOW  ? 6'h3F : 6'h00;
    localparam logic [6:0] SEG_IDLE = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_IDLE  = SEG_ACTIVE_LOW;

    // -------------------------------------------------------------------------
    // Slot counter / digit index
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             slot_end;
    logic             capture;

    assign slot_end = (cnt_q == CNT_LAST);
    assign capture  = en_i && slot_end && (idx_q == IDX_LAST);

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!en_i) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // -------------------------------------------------------------------------
    // Shadow bank: tracks the inputs while disabled, and otherwise only
    // reloads at the frame boundary so a running frame stays consistent.
    // -------------------------------------------------------------------------
    logic [5:0][4:0] shadow_q, shadow_d;
    logic [5:0]      sdp_q, sdp_d;
    logic [5:0][4:0] code_in;

    assign code_in = {in5_i, in4_i, in3_i, in2_i, in1_i, in0_i};

    always_comb begin
        shadow_d = shadow_q;
        sdp_d    = sdp_q;
        if (!en_i || capture) begin
            shadow_d = code_in;
            sdp_d    = dp_in_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= {NUM_DIGITS{SYM_BLANK}};
            sdp_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            sdp_q    <= sdp_d;
        end
    end

    // -------------------------------------------------------------------------
    // Decode of the digit currently being scanned
    // -------------------------------------------------------------------------
    logic [4:0] cur_code;
    logic [6:0] cur_pat;
    logic       cur_dp;

    assign cur_code = shadow_q[idx_q];
    assign cur_dp   = sdp_q[idx_q];

    seg7_decode u_decode (
        .code_i (cur_code),
        .seg_o  (cur_pat)
    );

    // -------------------------------------------------------------------------
    // Polarity stage and output registers. Segments keep following the
    // scanned digit during the blank window; only the anode is gated.
    // -------------------------------------------------------------------------
    logic [5:0] an_act;
    logic [5:0] an_d;
    logic [6:0] seg_d;
    logic       dp_d;
    logic       frame_tick_d;

    always_comb begin
        an_act = '0;
        if (en_i && (cnt_q >= BLANK_LIM)) begin
            an_act = 6'b00_0001 << idx_q;
        end
        an_d         = AN_ACTIVE_LOW  ? ~an_act  : an_act;
        seg_d        = SEG_ACTIVE_LOW ? ~cur_pat : cur_pat;
        dp_d         = SEG_ACTIVE_LOW ? ~cur_dp  : cur_dp;
        frame_tick_d = capture;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_o         <= AN_IDLE;
            seg_o        <= SEG_IDLE;
            dp_o         <= DP_IDLE;
            frame_tick_o <= 1'b0;
        end else begin
            an_o         <= an_d;
            seg_o        <= seg_d;
            dp_o         <= dp_d;
            frame_tick_o <= frame_tick_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 6 * SLOT;

    localparam logic [6:0] HEX_TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clk     = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst_n   = 1'b1;
    logic       en      = 1'b0;
    logic [4:0] in_v [6];
    logic [5:0] dp_in   = 6'h00;
    logic [5:0] an_o;
    logic [6:0] seg_o;
    logic       dp_o;
    logic       frame_tick_o;

    int total = 0;
    int bad   = 0;

    // reference model: frame position since enable plus the latched codes
    int         n;
    logic [4:0] sh [6];
    logic [5:0] sdp;
    logic [5:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_ft;

    always #5 if (clk_run) clk = ~clk;

    seg7_scan_driver #(
        .SLOT_CYC       (SLOT),
        .BLANK_CYC      (BLANK),
        .CNT_W          (4),
        .AN_ACTIVE_LOW  (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en),
        .in0_i        (in_v[0]),
        .in1_i        (in_v[1]),
        .in2_i        (in_v[2]),
        .in3_i        (in_v[3]),
        .in4_i        (in_v[4]),
        .in5_i        (in_v[5]),
        .dp_in_i      (dp_in),
        .an_o         (an_o),
        .seg_o        (seg_o),
        .dp_o         (dp_o),
        .frame_tick_o (frame_tick_o)
    );

    function automatic logic [6:0] ref_dec(input logic [4:0] c);
        if (c < 5'h10) return HEX_TBL[c[3:0]];
        if (c == 5'h11) return 7'h40;
        if (c == 5'h12) return 7'h73;
        if (c == 5'h13) return 7'h38;
        return 7'h00;
    endfunction

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < 6; i++) sh[i] = 5'h10;
        sdp     = 6'h00;
        exp_an  = 6'h3F;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
        exp_ft  = 1'b0;
    endtask

    // Predict what the outputs will hold after the coming edge, advance the
    // model, then move to one time unit past that edge.
    task automatic step();
        int digit, off;
        digit = n / SLOT;
        off   = n % SLOT;
        if (en) begin
            exp_an = (off >= BLANK) ? ~(6'b00_0001 << digit) : 6'h3F;
            exp_ft = (n == FRAME - 1);
        end else begin
            exp_an = 6'h3F;
            exp_ft = 1'b0;
        end
        exp_seg = ~ref_dec(sh[digit]);
        exp_dp  = ~sdp[digit];
        if (!en || n == FRAME - 1) begin
            for (int i = 0; i < 6; i++) sh[i] = in_v[i];
            sdp = dp_in;
        end
        n = en ? (n + 1) % FRAME : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) in_v[i] = 5'(i);
        #1 rst_n = 1'b0;
        #3;
        total++;
        if (an_o !== 6'h3F) begin bad++; $display("FAIL reset_an: got %h want 3f", an_o); end
        total++;
        if (seg_o !== 7'h7F) begin bad++; $display("FAIL reset_seg: got %h want 7f", seg_o); end
        total++;
        if (dp_o !== 1'b1) begin bad++; $display("FAIL reset_dp: got %b want 1", dp_o); end
        total++;
        if (frame_tick_o !== 1'b0) begin bad++; $display("FAIL reset_ft: got %b want 0", frame_tick_o); end
        model_reset();
        clk_run = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({an_o, seg_o, dp_o, frame_tick_o} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
                bad++;
                $display("FAIL idle: got an=%h seg=%h dp=%b ft=%b want an=%h seg=%h dp=%b ft=%b",
                         an_o, seg_o, dp_o, frame_tick_o, exp_an, exp_seg, exp_dp, exp_ft);
            end
        end
    endtask

    task automatic test_scan();
        int last_ft, nft;
        int on_cnt [6];
        last_ft = -1;
        nft     = 0;
        for (int d = 0; d < 6; d++) on_cnt[d] = 0;
        en = 1'b1;
        for (int i = 0; i < 3 * FRAME + 10; i++) begin
            step();
            total++;
            if ({an_o, seg_o, dp_o, frame_tick_o} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
                bad++;
                $display("FAIL scan_model: cyc=%0d got an=%h seg=%h ft=%b want an=%h seg=%h ft=%b",
                         i, an_o, seg_o, frame_tick_o, exp_an, exp_seg, exp_ft);
            end
            for (int d = 0; d < 6; d++)
                if (an_o == ~(6'b00_0001 << d)) on_cnt[d]++;
            if (an_o == 6'h3E) begin
                total++;
                if (seg_o !== 7'h40) begin bad++; $display("FAIL scan_seg0: got %h want 40", seg_o); end
            end
            if (frame_tick_o === 1'b1) begin
                if (last_ft >= 0) begin
                    total++;
                    if (i - last_ft != FRAME) begin
                        bad++;
                        $display("FAIL ft_period: got %0d want %0d", i - last_ft, FRAME);
                    end
                    for (int d = 0; d < 6; d++) begin
                        total++;
                        if (on_cnt[d] != SLOT - BLANK) begin
                            bad++;
                            $display("FAIL an_dwell%0d: got %0d want %0d", d, on_cnt[d], SLOT - BLANK);
                        end
                    end
                end
                for (int d = 0; d < 6; d++) on_cnt[d] = 0;
                last_ft = i;
                nft++;
            end
        end
        total++;
        if (nft < 3) begin bad++; $display("FAIL ft_count: got %0d want >=3", nft); end
    endtask

    task automatic test_tear();
        int seen_old, seen_new;
        logic after_ft;
        logic [6:0] want;
        seen_old = 0;
        seen_new = 0;
        after_ft = 1'b0;
        for (int i = 0; i < FRAME && (n / SLOT) != 1; i++) step();
        in_v[3] = 5'd9;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            total++;
            if ({an_o, seg_o, dp_o, frame_tick_o} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
                bad++;
                $display("FAIL tear_model: cyc=%0d got an=%h seg=%h want an=%h seg=%h",
                         i, an_o, seg_o, exp_an, exp_seg);
            end
            if (frame_tick_o === 1'b1) after_ft = 1'b1;
            if (an_o == 6'h37) begin
                want = after_ft ? 7'h10 : 7'h30;
                if (after_ft) seen_new++; else seen_old++;
                total++;
                if (seg_o !== want) begin bad++; $display("FAIL tear_seg: got %h want %h", seg_o, want); end
            end
        end
        total++;
        if (seen_old == 0 || seen_new == 0) begin
            bad++;
            $display("FAIL tear_cover: old=%0d new=%0d want both >0", seen_old, seen_new);
        end
    endtask

    task automatic test_symbols();
        logic armed;
        logic [7:0] want;
        armed   = 1'b0;
        in_v[0] = 5'h10;
        in_v[1] = 5'h11;
        in_v[2] = 5'h1F;
        dp_in   = 6'h01;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            total++;
            if ({an_o, seg_o, dp_o, frame_tick_o} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
                bad++;
                $display("FAIL sym_model: cyc=%0d got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                         i, an_o, seg_o, dp_o, exp_an, exp_seg, exp_dp);
            end
            if (frame_tick_o === 1'b1) armed = 1'b1;
            if (armed && an_o != 6'h3F) begin
                case (an_o)
                    6'h3E:   want = {7'h7F, 1'b0};
                    6'h3D:   want = {7'h3F, 1'b1};
                    6'h3B:   want = {7'h7F, 1'b1};
                    default: want = {seg_o, 1'b1};
                endcase
                total++;
                if ({seg_o, dp_o} !== want) begin
                    bad++;
                    $display("FAIL sym_seg_dp: an=%h got seg=%h dp=%b want seg=%h dp=%b",
                             an_o, seg_o, dp_o, want[7:1], want[0]);
                end
            end
        end
        dp_in = 6'h00;
    endtask

    task automatic test_enable();
        for (int i = 0; i < FRAME && n != 2 * SLOT + 4; i++) step();
        en = 1'b0;
        step();
        total++;
        if (an_o !== 6'h3F) begin bad++; $display("FAIL en_off_an: got %h want 3f", an_o); end
        total++;
        if (dut.cnt_q !== 4'd0 || dut.idx_q !== 3'd0) begin
            bad++;
            $display("FAIL en_off_cnt: got cnt=%0d idx=%0d want 0 0", dut.cnt_q, dut.idx_q);
        end
        for (int i = 0; i < 3; i++) begin
            in_v[4] = 5'($urandom_range(0, 31));
            step();
            total++;
            if ({an_o, seg_o, dp_o, frame_tick_o} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
                bad++;
                $display("FAIL en_off_model: got an=%h seg=%h ft=%b want an=%h seg=%h ft=%b",
                         an_o, seg_o, frame_tick_o, exp_an, exp_seg, exp_ft);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (an_o !== ((i < BLANK) ? 6'h3F : 6'h3E)) begin
                bad++;
                $display("FAIL en_on_an%0d: got %h want %h", i, an_o, (i < BLANK) ? 6'h3F : 6'h3E);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) in_v[$urandom_range(0, 5)] = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) dp_in = 6'($urandom_range(0, 63));
            if (en && $urandom_range(0, 59) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            step();
            total++;
            if ({an_o, seg_o, dp_o, frame_tick_o} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
                bad++;
                $display("FAIL rand_model: cyc=%0d got an=%h seg=%h dp=%b ft=%b want an=%h seg=%h dp=%b ft=%b",
                         i, an_o, seg_o, dp_o, frame_tick_o, exp_an, exp_seg, exp_dp, exp_ft);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic before_ft;
        before_ft = 1'b1;
        for (int i = 0; i < 2 * FRAME && n != 3 * SLOT + 5; i++) step();
        for (int i = 0; i < 6; i++) in_v[i] = 5'($urandom_range(0, 15));
        rst_n = 1'b0;
        #2;
        total++;
        if ({an_o, seg_o, dp_o, frame_tick_o} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL rst_async: got an=%h seg=%h dp=%b ft=%b want 3f 7f 1 0",
                     an_o, seg_o, dp_o, frame_tick_o);
        end
        model_reset();
        @(posedge clk);
        #1;
        total++;
        if ({an_o, seg_o, dp_o, frame_tick_o} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL rst_hold: got an=%h seg=%h dp=%b ft=%b want 3f 7f 1 0",
                     an_o, seg_o, dp_o, frame_tick_o);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            total++;
            if ({an_o, seg_o, dp_o, frame_tick_o} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
                bad++;
                $display("FAIL rst_model: cyc=%0d got an=%h seg=%h want an=%h seg=%h",
                         i, an_o, seg_o, exp_an, exp_seg);
            end
            if (frame_tick_o === 1'b1) before_ft = 1'b0;
            if (before_ft) begin
                total++;
                if (seg_o !== 7'h7F) begin bad++; $display("FAIL rst_blank: got %h want 7f", seg_o); end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_scan();
        test_tear();
        test_symbols();
        test_enable();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
